// File: rtl/full_adder_reg.sv
// Registered ripple-carry full adder: sum/carry = x + y + z, optionally
// captured behind in_valid with a one-cycle latency.
module full_adder_reg #(
    parameter int unsigned WIDTH   = 1,
    parameter bit          OUT_REG = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             z,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             out_valid
);

    logic [WIDTH-1:0] add_sum;
    logic [WIDTH:0]   chain;

    // Ripple of 1-bit full-adder cells; z enters at bit 0.
    always_comb begin
        add_sum  = '0;
        chain    = '0;
        chain[0] = z;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            add_sum[i]   = x[i] ^ y[i] ^ chain[i];
            chain[i + 1] = (x[i] & y[i]) | (x[i] & chain[i]) | (y[i] & chain[i]);
        end
    end

    if (OUT_REG) begin : g_reg
        logic [WIDTH-1:0] sum_d,       sum_q;
        logic             carry_d,     carry_q;
        logic             out_valid_d, out_valid_q;

        always_comb begin
            sum_d       = sum_q;
            carry_d     = carry_q;
            out_valid_d = in_valid;
            if (in_valid) begin
                sum_d   = add_sum;
                carry_d = chain[WIDTH];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sum_q       <= '0;
                carry_q     <= 1'b0;
                out_valid_q <= 1'b0;
            end else begin
                sum_q       <= sum_d;
                carry_q     <= carry_d;
                out_valid_q <= out_valid_d;
            end
        end

        assign sum       = sum_q;
        assign carry     = carry_q;
        assign out_valid = out_valid_q;
    end else begin : g_comb
        // Clock and reset have no role on the purely combinational path.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;

        assign sum       = add_sum;
        assign carry     = chain[WIDTH];
        assign out_valid = in_valid;
    end

endmodule

// File: tb/tb_full_adder_reg.sv
// Directed bench for full_adder_reg: WIDTH=1 and WIDTH=8 registered
// instances plus a WIDTH=8 combinational instance sharing the 8-bit inputs.
module tb_full_adder_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       v1, x1, y1, z1;
    logic       s1, c1, ov1;
    logic       v8, z8;
    logic [7:0] x8, y8;
    logic [7:0] s8, s0;
    logic       c8, ov8, c0, ov0;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] s;
        logic       co;
    } vec8_t;

    // {x, y, z, sum, carry}
    logic [4:0] vec1 [5] = '{5'b000_00, 5'b011_01, 5'b101_01, 5'b110_01, 5'b111_11};
    vec8_t      vec8 [5] = '{
        '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1},
        '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1},
        '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0},
        '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1},
        '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1}
    };

    full_adder_reg #(.WIDTH(1), .OUT_REG(1'b1)) u1 (
        .clk(clk), .rst(rst), .in_valid(v1), .x(x1), .y(y1), .z(z1),
        .sum(s1), .carry(c1), .out_valid(ov1)
    );

    full_adder_reg #(.WIDTH(8), .OUT_REG(1'b1)) u8 (
        .clk(clk), .rst(rst), .in_valid(v8), .x(x8), .y(y8), .z(z8),
        .sum(s8), .carry(c8), .out_valid(ov8)
    );

    full_adder_reg #(.WIDTH(8), .OUT_REG(1'b0)) u0 (
        .clk(clk), .rst(rst), .in_valid(v8), .x(x8), .y(y8), .z(z8),
        .sum(s0), .carry(c0), .out_valid(ov0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] xyz;
        logic [4:0] v;

        // Reset with random inputs, before any clock edge.
        rst = 1'b1;
        v1 = 1'b1; x1 = 1'($urandom); y1 = 1'($urandom); z1 = 1'($urandom);
        v8 = 1'b1; x8 = 8'($urandom); y8 = 8'($urandom); z8 = 1'($urandom);
        #1;
        check("rst_w1", {30'd0, s1, c1, ov1}, 32'd0);
        check("rst_w8", {23'd0, s8, c8, ov8}, 32'd0);
        step();
        check("rst_edge_w8", {23'd0, s8, c8, ov8}, 32'd0);
        rst = 1'b0; v1 = 1'b0; v8 = 1'b0;
        step();
        check("post_rst_w1", {30'd0, s1, c1, ov1}, 32'd0);
        check("post_rst_w8", {23'd0, s8, c8, ov8}, 32'd0);
        check("comb_ov_idle", {31'd0, ov0}, 32'd0);

        // WIDTH=1 directed vectors, back-to-back.
        for (int i = 0; i < 5; i++) begin
            v = vec1[i];
            v1 = 1'b1; x1 = v[4]; y1 = v[3]; z1 = v[2];
            step();
            check($sformatf("w1_vec%0d", i), {29'd0, s1, c1, ov1}, {29'd0, v[1], v[0], 1'b1});
        end

        // Exhaustive sweep against the truth-table formulas.
        for (int i = 0; i < 8; i++) begin
            xyz = 3'(i);
            x1 = xyz[2]; y1 = xyz[1]; z1 = xyz[0];
            step();
            check($sformatf("w1_sweep%0d", i), {29'd0, s1, c1, ov1},
                  {29'd0, xyz[2] ^ xyz[1] ^ xyz[0],
                   (xyz[2] & xyz[1]) | (xyz[2] & xyz[0]) | (xyz[1] & xyz[0]), 1'b1});
        end

        // Hold: result retained, out_valid drops.
        x1 = 1'b1; y1 = 1'b1; z1 = 1'b1;
        step();
        check("hold_load", {29'd0, s1, c1, ov1}, 32'b111);
        v1 = 1'b0; x1 = 1'b0; y1 = 1'b0; z1 = 1'b0;
        step();
        check("hold_keep", {29'd0, s1, c1, ov1}, 32'b110);
        step();
        check("hold_keep2", {29'd0, s1, c1, ov1}, 32'b110);

        // WIDTH=8 vectors, back-to-back; the combinational copy checked before the edge.
        for (int i = 0; i < 5; i++) begin
            v8 = 1'b1; x8 = vec8[i].a; y8 = vec8[i].b; z8 = vec8[i].ci;
            #1;
            check($sformatf("comb_vec%0d", i), {22'd0, s0, c0, ov0}, {22'd0, vec8[i].s, vec8[i].co, 1'b1});
            if (i > 0)
                check($sformatf("w8_unchanged%0d", i), {23'd0, s8, c8}, {23'd0, vec8[i-1].s, vec8[i-1].co});
            step();
            check($sformatf("w8_vec%0d", i), {22'd0, s8, c8, ov8}, {22'd0, vec8[i].s, vec8[i].co, 1'b1});
        end

        // Mid-stream asynchronous reset.
        x8 = 8'h12; y8 = 8'h34; z8 = 1'b1;
        step();
        check("mid_a", {22'd0, s8, c8, ov8}, {22'd0, 8'h47, 1'b0, 1'b1});
        x8 = 8'hFF; y8 = 8'h01; z8 = 1'b0;
        #3 rst = 1'b1;
        #1;
        check("mid_async_clr", {22'd0, s8, c8, ov8}, 32'd0);
        step();
        check("mid_no_capture", {22'd0, s8, c8, ov8}, 32'd0);
        #2 rst = 1'b0; v8 = 1'b0;
        step();
        check("mid_released_idle", {22'd0, s8, c8, ov8}, 32'd0);
        v8 = 1'b1; x8 = 8'hA5; y8 = 8'h5A; z8 = 1'b1;
        step();
        check("mid_after", {22'd0, s8, c8, ov8}, {22'd0, 8'h00, 1'b1, 1'b1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
